// File: rtl/hbm_write_scheduler_pkg.sv
// Shared types and constants for the HBM write scheduler.
// The descriptor address field is sized to the default HBM byte-address width.
package hbm_wr_sched_pkg;

  localparam int SETUP_CYCLES = 2;
  localparam int BURST_ALIGN  = 32;
  localparam int HBM_ADDR_W   = 33;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [31:0]           ops;
    logic [31:0]           stride;
    logic [HBM_ADDR_W-1:0] addr;
    logic [15:0]           burst;
  } desc_t;

  // Zero-length or non-32-byte-multiple bursts cannot be issued to the engine.
  function automatic logic burst_bad(input logic [15:0] burst);
    return (burst == 16'd0) || ((burst & 16'(BURST_ALIGN - 1)) != 16'd0);
  endfunction

endpackage

// File: rtl/hbm_write_scheduler_if.sv
// Requester-side descriptor/completion bundle for the HBM write scheduler.
// The master side is the layer controllers; the slave side is the scheduler.
interface hbm_wr_sched_if
  import hbm_wr_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = HBM_ADDR_W,
  parameter int DATA_WIDTH = 256
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*32-1:0]         req_ops;
  logic [NUM_REQ*32-1:0]         req_stride;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*16-1:0]         req_burst;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat;
  logic [NUM_REQ-1:0]            req_done;
  logic                          req_err;

  modport master (
    output req_valid, req_ops, req_stride, req_addr, req_burst, req_dat,
    input  req_ready, req_done, req_err
  );

  modport slave (
    input  req_valid, req_ops, req_stride, req_addr, req_burst, req_dat,
    output req_ready, req_done, req_err
  );
endinterface

// File: rtl/hbm_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
// Produces both a one-hot grant and the binary index of the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IW = $clog2(NUM_REQ);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/hbm_write_scheduler.sv
// Round-robin scheduler feeding write jobs from NUM_REQ requesters to one HBM
// write engine; completion is tracked by counting B responses.
//   state  | meaning
//   IDLE   | waiting for a descriptor; accepts the round-robin winner
//   SETUP  | letting the engine's registered config settle
//   LAUNCH | one-cycle engine start pulse
//   RUN    | counting B responses until the job's burst count is reached
//   DONE   | one-cycle completion pulse to the job owner
module hbm_write_scheduler
  import hbm_wr_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = HBM_ADDR_W,
  parameter int DATA_WIDTH = 256,
  parameter int WDOG_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  hbm_wr_sched_if.slave              req,
  output logic                       eng_start,
  output logic [31:0]                eng_write_ops,
  output logic [31:0]                eng_stride,
  output logic [ADDR_WIDTH-1:0]      eng_init_addr,
  output logic [15:0]                eng_burst_size,
  output logic [DATA_WIDTH-1:0]      eng_up_dat,
  input  logic                       axi_bvalid,
  input  logic [1:0]                 axi_bresp,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       wdog_flag
);
  localparam int IW  = $clog2(NUM_REQ);
  localparam int SCW = $clog2(SETUP_CYCLES + 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic            any_req;
  logic            skip_launch;
  desc_t           sel;
  logic [SCW-1:0]  setup_cnt;
  logic [31:0]     bcnt;
  logic            err_acc;
  logic            last_b;
  logic [WDOG_WIDTH-1:0] wdog_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req.req_valid),
    .ptr (rr_ptr),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  always_comb begin
    sel        = '0;
    sel.ops    = req.req_ops[int'(win_idx)*32 +: 32];
    sel.stride = req.req_stride[int'(win_idx)*32 +: 32];
    sel.addr   = HBM_ADDR_W'(req.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
    sel.burst  = req.req_burst[int'(win_idx)*16 +: 16];
  end

  assign any_req     = |req.req_valid;
  assign skip_launch = (sel.ops == 32'd0) || burst_bad(sel.burst);
  assign last_b      = axi_bvalid && (bcnt == eng_write_ops - 32'd1);
  assign busy        = (state != IDLE);
  assign eng_up_dat  = req.req_dat[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req.req_ready = '0;
    req.req_done  = '0;
    req.req_err   = 1'b0;
    eng_start     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req.req_ready = win_gnt;
          state_nxt     = skip_launch ? DONE : SETUP;
        end
      end
      SETUP:  if (setup_cnt == SCW'(SETUP_CYCLES - 1)) state_nxt = LAUNCH;
      LAUNCH: begin
        eng_start = 1'b1;
        state_nxt = RUN;
      end
      RUN:    if (last_b) state_nxt = DONE;
      DONE: begin
        req.req_done[grant_id] = 1'b1;
        req.req_err            = err_acc;
        state_nxt              = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_write_ops  <= '0;
      eng_stride     <= '0;
      eng_init_addr  <= '0;
      eng_burst_size <= '0;
      grant_id       <= '0;
      rr_ptr         <= '0;
      setup_cnt      <= '0;
      bcnt           <= '0;
      err_acc        <= 1'b0;
      wdog_cnt       <= '0;
      wdog_flag      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            eng_write_ops  <= sel.ops;
            eng_stride     <= sel.stride;
            eng_init_addr  <= ADDR_WIDTH'(sel.addr);
            eng_burst_size <= sel.burst;
            grant_id       <= win_idx;
            rr_ptr         <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            // An empty job completes cleanly even if its burst field is junk.
            err_acc        <= (sel.ops != 32'd0) && burst_bad(sel.burst);
            setup_cnt      <= '0;
          end
        end
        SETUP: setup_cnt <= setup_cnt + 1'b1;
        LAUNCH: begin
          bcnt     <= '0;
          err_acc  <= 1'b0;
          wdog_cnt <= '0;
        end
        RUN: begin
          if (axi_bvalid) begin
            bcnt     <= bcnt + 32'd1;
            wdog_cnt <= '0;
            if (axi_bresp != 2'b00) err_acc <= 1'b1;
          end else if (wdog_cnt != '1) begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      // The engine cannot be cancelled, so a stall is only flagged.
      if (state == RUN && wdog_cnt == '1) wdog_flag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hbm_write_scheduler.sv
// Scoreboard bench for hbm_write_scheduler: stimulus queues expected accept,
// start and done events; a negedge monitor pops and compares them.
module tb_hbm_write_scheduler;
  import hbm_wr_sched_pkg::*;

  localparam int NR = 4;
  localparam int AW = 33;
  localparam int DW = 256;
  localparam int WW = 6;

  localparam int K_ACC   = 0;
  localparam int K_START = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int          kind;
    int          id;
    int          err;
    longint      addr;
    int          ops;
    int          stride;
    int          burst;
    bit          launched;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          eng_start;
  logic [31:0]   eng_write_ops;
  logic [31:0]   eng_stride;
  logic [AW-1:0] eng_init_addr;
  logic [15:0]   eng_burst_size;
  logic [DW-1:0] eng_up_dat;
  logic          axi_bvalid = 1'b0;
  logic [1:0]    axi_bresp = 2'b00;
  logic [1:0]    grant_id;
  logic          busy;
  logic          wdog_flag;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  hbm_wr_sched_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rif ();

  hbm_write_scheduler #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WDOG_WIDTH(WW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (rif),
    .eng_start      (eng_start),
    .eng_write_ops  (eng_write_ops),
    .eng_stride     (eng_stride),
    .eng_init_addr  (eng_init_addr),
    .eng_burst_size (eng_burst_size),
    .eng_up_dat     (eng_up_dat),
    .axi_bvalid     (axi_bvalid),
    .axi_bresp      (axi_bresp),
    .grant_id       (grant_id),
    .busy           (busy),
    .wdog_flag      (wdog_flag)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input longint act, input longint req_v);
    total++;
    if (act != req_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
    end
  endfunction

  function automatic logic [DW-1:0] dat_of(input int id);
    logic [31:0] w;
    w = 32'hDA7A_0000 + 32'(id);
    return {8{w}};
  endfunction

  // Monitor
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_b = 0;
  logic [NR-1:0] prev_ready = '0;
  exp_t        me;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ready = '0;
    end else begin
      cyc++;
      if (rif.req_ready != '0) begin
        if (exp_q.size() == 0) chk("unexpected_accept", longint'(rif.req_ready), 0);
        else begin
          me = exp_q.pop_front();
          chk("accept_kind", me.kind, K_ACC);
          chk("ready_onehot", longint'(rif.req_ready), longint'(1) << me.id);
          chk("ready_pulse", longint'(prev_ready), 0);
          acc_cyc = cyc;
        end
      end
      if (eng_start) begin
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          me = exp_q.pop_front();
          chk("start_kind", me.kind, K_START);
          chk("start_latency", cyc - acc_cyc, 3);
          chk("grant_id", longint'(grant_id), me.id);
          chk("eng_write_ops", longint'(eng_write_ops), me.ops);
          chk("eng_stride", longint'(eng_stride), me.stride);
          chk("eng_init_addr", longint'(eng_init_addr), me.addr);
          chk("eng_burst_size", longint'(eng_burst_size), me.burst);
          chk("eng_up_dat", longint'(eng_up_dat == dat_of(me.id)), 1);
        end
      end
      if (rif.req_done != '0) begin
        if (exp_q.size() == 0) chk("unexpected_done", longint'(rif.req_done), 0);
        else begin
          me = exp_q.pop_front();
          chk("done_kind", me.kind, K_DONE);
          chk("done_id", longint'(rif.req_done), longint'(1) << me.id);
          chk("done_err", longint'(rif.req_err), me.err);
          if (me.launched) begin
            chk("b_to_done", cyc - last_b, 1);
            chk("hold_addr", longint'(eng_init_addr), me.addr);
          end else begin
            chk("accept_to_done", cyc - acc_cyc, 1);
          end
        end
      end
      if (axi_bvalid) last_b = cyc;
      prev_ready = rif.req_ready;
    end
  end

  // Stimulus helpers
  task automatic set_desc(input int id, input int ops, input int stride,
                          input longint addr, input int burst);
    logic [63:0] a;
    a = 64'(addr);
    rif.req_ops[id*32 +: 32]    = 32'(ops);
    rif.req_stride[id*32 +: 32] = 32'(stride);
    rif.req_addr[id*AW +: AW]   = a[AW-1:0];
    rif.req_burst[id*16 +: 16]  = 16'(burst);
  endtask

  task automatic push_job(input int id, input int ops, input int stride,
                          input longint addr, input int burst, input int err);
    exp_t e;
    e.id = id; e.ops = ops; e.stride = stride; e.addr = addr; e.burst = burst;
    e.err = err;
    e.launched = (ops != 0) && (burst != 0) && (burst % 32 == 0);
    e.kind = K_ACC;  exp_q.push_back(e);
    if (e.launched) begin e.kind = K_START; exp_q.push_back(e); end
    e.kind = K_DONE; exp_q.push_back(e);
  endtask

  task automatic wait_accept(input int id);
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (rif.req_ready[id]) seen = 1'b1;
    end
    if (!seen) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    rif.req_valid[id] = 1'b0;
  endtask

  task automatic wait_start();
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (eng_start) seen = 1'b1;
    end
    if (!seen) chk("start_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [1:0] resp);
    axi_bvalid = 1'b1;
    axi_bresp  = resp;
    @(posedge clk); #1;
    axi_bvalid = 1'b0;
    axi_bresp  = 2'b00;
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    if (!seen) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int id, input int ops, input int stride,
                         input longint addr, input int burst, input int err);
    push_job(id, ops, stride, addr, burst, err);
    set_desc(id, ops, stride, addr, burst);
    rif.req_valid[id] = 1'b1;
    wait_accept(id);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, longint'(rif.req_ready), 0);
    chk({tag, "_done"}, longint'(rif.req_done), 0);
    chk({tag, "_err"}, longint'(rif.req_err), 0);
    chk({tag, "_start"}, longint'(eng_start), 0);
    chk({tag, "_ops"}, longint'(eng_write_ops), 0);
    chk({tag, "_stride"}, longint'(eng_stride), 0);
    chk({tag, "_addr"}, longint'(eng_init_addr), 0);
    chk({tag, "_burst"}, longint'(eng_burst_size), 0);
    chk({tag, "_grant"}, longint'(grant_id), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_wdog"}, longint'(wdog_flag), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rif.req_valid  = '0;
    rif.req_ops    = '0;
    rif.req_stride = '0;
    rif.req_addr   = '0;
    rif.req_burst  = '0;
    for (int i = 0; i < NR; i++) rif.req_dat[i*DW +: DW] = dat_of(i);

    #12;
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four requesters valid together, one burst each: grants 0,1,2,3,0.
    for (int i = 0; i < NR; i++) set_desc(i, 1, 32'h20 * (i + 1), 64'h10000 * (i + 1), 32);
    push_job(0, 1, 32'h20, 64'h10000, 32, 0);
    push_job(1, 1, 32'h40, 64'h20000, 32, 0);
    push_job(2, 1, 32'h60, 64'h30000, 32, 0);
    push_job(3, 1, 32'h80, 64'h40000, 32, 0);
    push_job(0, 1, 32'h20, 64'h10000, 32, 0);
    rif.req_valid = '1;
    for (int j = 0; j < 5; j++) begin
      wait_start();
      if (j == 4) rif.req_valid = '0;
      send_b(2'b00);
    end
    wait_idle();

    // Single requester, four OKAY responses.
    run_job(0, 4, 32'h1000, 64'h100, 64, 0);
    wait_start();
    for (int k = 0; k < 4; k++) send_b(2'b00);
    wait_idle();

    // Error on the second response, then a clean job.
    run_job(2, 3, 32'h80, 64'h1000, 128, 1);
    wait_start();
    send_b(2'b00); send_b(2'b10); send_b(2'b00);
    wait_idle();
    run_job(3, 1, 32'h40, 64'h5000, 32, 0);
    wait_start();
    send_b(2'b00);
    wait_idle();

    // Degenerate descriptors complete without launching.
    run_job(1, 0, 32'h40, 64'h600, 64, 0);
    wait_idle();
    run_job(1, 2, 32'h40, 64'h700, 48, 1);
    wait_idle();

    // Stalled B channel trips the watchdog; the job still finishes later.
    run_job(0, 2, 32'h40, 64'h2000, 32, 0);
    wait_start();
    chk("wdog_before", longint'(wdog_flag), 0);
    repeat (70) @(posedge clk);
    #1;
    chk("wdog_set", longint'(wdog_flag), 1);
    chk("wdog_busy", longint'(busy), 1);
    send_b(2'b00); send_b(2'b00);
    wait_idle();
    chk("wdog_sticky", longint'(wdog_flag), 1);

    // Reset in the middle of a job.
    run_job(0, 3, 32'h40, 64'h300, 32, 0);
    wait_start();
    send_b(2'b00);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(0, 1, 32'h40, 64'h400, 32, 0);
    wait_start();
    send_b(2'b00);
    wait_idle();

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
